// File: rtl/uart_rx_if.sv
// Receive-side payload bundle of the 8N1 UART receiver.
// The receiver drives it through master; the byte consumer reads it through slave.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx_data, output rx_valid, output frame_err, output busy);
  modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, oversampled bit timing and mid-cell
// 3-sample majority vote, with a byte-valid strobe and a framing-error strobe.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned S_W   = $clog2(OVERSAMPLE);
  localparam int unsigned HALF  = OVERSAMPLE / 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic [S_W-1:0]   s_cnt;
  logic [1:0]       vote;
  logic [3:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             armed;

  logic tick;
  logic resolve;
  logic bit_val;

  assign tick    = (div_cnt == DIV_W'(DIV - 1));
  assign resolve = tick && (s_cnt == S_W'(HALF + 1));
  // Third vote is the live sample taken at the resolve tick itself.
  assign bit_val = (vote[0] & vote[1]) | (vote[0] & rx_s) | (vote[1] & rx_s);

  // Synchroniser presets to the idle-high line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      div_cnt       <= '0;
      s_cnt         <= '0;
      vote          <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      armed         <= 1'b1;
      bus.rx_data   <= 8'h00;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      if (rx_s) armed <= 1'b1;

      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        s_cnt <= (s_cnt == S_W'(OVERSAMPLE - 1)) ? '0 : s_cnt + S_W'(1);
        if (s_cnt == S_W'(HALF - 1)) vote[0] <= rx_s;
        if (s_cnt == S_W'(HALF))     vote[1] <= rx_s;
      end

      case (state)
        IDLE: begin
          // Restart bit timing on the start edge so sampling is edge-aligned.
          if (!rx_s && armed) begin
            state    <= START;
            div_cnt  <= '0;
            s_cnt    <= '0;
            bus.busy <= 1'b1;
          end
        end
        START: begin
          if (resolve) begin
            if (!bit_val) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        DATA: begin
          if (resolve) begin
            shift_reg <= {bit_val, shift_reg[7:1]};
            bit_idx   <= bit_idx + 4'd1;
          end
          if (tick && (s_cnt == S_W'(OVERSAMPLE - 1)) && (bit_idx == 4'd8))
            state <= STOP;
        end
        STOP: begin
          // Leaving mid-cell leaves room to catch an immediately following start edge.
          if (resolve) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            if (bit_val) begin
              bus.rx_data  <= shift_reg;
              bus.rx_valid <= 1'b1;
            end else begin
              bus.frame_err <= 1'b1;
              armed         <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven bit by bit, expected bytes
// go to a scoreboard queue and are popped when the receiver strobes rx_valid.
module tb_uart_rx;

  localparam int P = 160;

  logic clk;
  logic reset_n;
  logic rx;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_FREQ  (1536000),
    .BAUD_RATE (9600),
    .OVERSAMPLE(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rx     (rx),
    .bus    (bus)
  );

  int total;
  int passed;
  int cyc;
  int valid_cnt;
  int err_cnt;
  int last_valid_cyc;
  int prev_valid_cyc;
  int frame_start_cyc;
  logic prev_valid;
  logic prev_err;
  logic [7:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard and strobe-shape monitor.
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset_n) begin
      if (prev_valid) begin
        total++;
        if (bus.rx_valid !== 1'b0) $display("FAIL valid_width: rx_valid=%b required 0", bus.rx_valid);
        else passed++;
      end
      if (prev_err) begin
        total++;
        if (bus.frame_err !== 1'b0) $display("FAIL err_width: frame_err=%b required 0", bus.frame_err);
        else passed++;
      end
      if (bus.rx_valid || bus.frame_err) begin
        total++;
        if (bus.rx_valid && bus.frame_err) $display("FAIL exclusive: rx_valid=1 frame_err=1 required not both");
        else passed++;
      end
      if (bus.rx_valid) begin
        valid_cnt++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_valid: rx_data=%02h with no byte expected", bus.rx_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.rx_data !== e) $display("FAIL scoreboard: rx_data=%02h required %02h", bus.rx_data, e);
          else passed++;
        end
      end
      if (bus.frame_err) err_cnt++;
      prev_valid = bus.rx_valid;
      prev_err   = bus.frame_err;
    end else begin
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input int p);
    frame_start_cyc = cyc;
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (p) @(negedge clk);
    end
    rx = stop;
    repeat (p) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic good_frame(input string name, input logic [7:0] d, input int p);
    int v0;
    v0 = valid_cnt;
    exp_q.push_back(d);
    send_frame(d, 1'b1, p);
    for (int i = 0; i < 200 && valid_cnt == v0; i++) @(negedge clk);
    total++;
    if (valid_cnt - v0 !== 1) $display("FAIL %s_count: valid pulses=%0d required 1", name, valid_cnt - v0);
    else passed++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy} !== 11'h0)
      $display("FAIL reset_outputs: data=%02h v=%b e=%b busy=%b required all 0",
               bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy);
    else passed++;
    reset_n = 1'b1;
    repeat (2 * P) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) $display("FAIL idle_busy: busy=%b required 0", bus.busy);
    else passed++;
  endtask

  task automatic test_basic();
    int lat;
    good_frame("basic", 8'hA5, P);
    lat = last_valid_cyc - frame_start_cyc;
    total++;
    if (lat < 1500 || lat > 1560) $display("FAIL basic_latency: latency=%0d clk required 1500..1560", lat);
    else passed++;
    repeat (4) @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy: busy=%b required 0", bus.busy);
    else passed++;
    total++;
    if (bus.rx_data !== 8'hA5) $display("FAIL basic_hold: rx_data=%02h required a5", bus.rx_data);
    else passed++;
  endtask

  task automatic test_glitch();
    int v0, e0, n;
    v0 = valid_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) $display("FAIL glitch_busy_rise: busy=%b required 1", bus.busy);
    else passed++;
    rx = 1'b1;
    n = 0;
    while (bus.busy !== 1'b0 && n < P) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.busy !== 1'b0) $display("FAIL glitch_busy_drop: busy=%b required 0 within %0d clk", bus.busy, P);
    else passed++;
    repeat (P) @(negedge clk);
    total++;
    if (valid_cnt !== v0 || err_cnt !== e0)
      $display("FAIL glitch_pulses: valid=%0d err=%0d required 0 0", valid_cnt - v0, err_cnt - e0);
    else passed++;
    good_frame("after_glitch", 8'h5A, P);
  endtask

  task automatic test_frame_err();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0, P);
    repeat (2 * P) @(negedge clk);
    total++;
    if (err_cnt - e0 !== 1) $display("FAIL ferr_count: frame_err pulses=%0d required 1", err_cnt - e0);
    else passed++;
    total++;
    if (valid_cnt !== v0) $display("FAIL ferr_valid: rx_valid pulses=%0d required 0", valid_cnt - v0);
    else passed++;
    total++;
    if (bus.rx_data !== 8'h5A) $display("FAIL ferr_hold: rx_data=%02h required 5a", bus.rx_data);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int gap;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, P);
    send_frame(8'hFF, 1'b1, P);
    repeat (100) @(negedge clk);
    gap = last_valid_cyc - prev_valid_cyc;
    total++;
    if (gap < 1595 || gap > 1605) $display("FAIL b2b_gap: gap=%0d clk required 1595..1605", gap);
    else passed++;
    total++;
    if (bus.rx_data !== 8'hFF) $display("FAIL b2b_last: rx_data=%02h required ff", bus.rx_data);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    logic [7:0] d;
    d  = 8'h81;
    v0 = valid_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (P) @(negedge clk);
    end
    rx = d[4];
    repeat (P / 2) @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) $display("FAIL midrst_busy_before: busy=%b required 1", bus.busy);
    else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy} !== 11'h0)
      $display("FAIL midrst_outputs: data=%02h v=%b e=%b busy=%b required all 0",
               bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy);
    else passed++;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * P) @(negedge clk);
    total++;
    if (valid_cnt !== v0 || err_cnt !== e0)
      $display("FAIL midrst_pulses: valid=%0d err=%0d required 0 0", valid_cnt - v0, err_cnt - e0);
    else passed++;
    good_frame("after_reset", 8'h81, P);
  endtask

  task automatic test_break();
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (20 * P) @(negedge clk);
    total++;
    if (err_cnt - e0 !== 1) $display("FAIL break_err_count: frame_err pulses=%0d required 1", err_cnt - e0);
    else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL break_idle: busy=%b required 0", bus.busy);
    else passed++;
    rx = 1'b1;
    repeat (2 * P) @(negedge clk);
    total++;
    if (valid_cnt !== v0 || err_cnt - e0 !== 1)
      $display("FAIL break_pulses: valid=%0d err=%0d required 0 1", valid_cnt - v0, err_cnt - e0);
    else passed++;
    good_frame("after_break", 8'h42, P);
  endtask

  task automatic test_jitter();
    good_frame("slow", 8'hA5, P + P * 3 / 100);
    repeat (P) @(negedge clk);
    good_frame("fast", 8'hA5, P - P * 3 / 100);
    repeat (P) @(negedge clk);
    total++;
    if (bus.rx_data !== 8'hA5) $display("FAIL jitter_hold: rx_data=%02h required a5", bus.rx_data);
    else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    cyc = 0;
    valid_cnt = 0;
    err_cnt = 0;
    last_valid_cyc = 0;
    prev_valid_cyc = 0;
    frame_start_cyc = 0;
    prev_valid = 1'b0;
    prev_err = 1'b0;
    reset_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    test_jitter();
    total++;
    if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d bytes left required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
